// File: rtl/inst_fetch_axi.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_axi
//  Function : Instruction fetch stage. Turns each PC into one AXI4-Lite read,
//             returns the fetched word and holds the PC via stallreq until
//             the word arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_axi (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic        flush,
  input  logic        id_stall,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_err,
  output logic        stallreq,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  // Unprivileged, secure, instruction access
  localparam logic [2:0] c_ARPROT_INST = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_drop;

  logic   w_start;
  logic   w_misal;
  logic   w_misal_fire;
  logic   w_rd_done;
  logic   w_discard;

  assign arprot       = c_ARPROT_INST;
  assign w_start      = ce && !flush && !id_stall;
  assign w_misal      = (pc[1:0] != 2'b00);
  assign w_misal_fire = (r_state == IDLE) && w_start && w_misal;
  assign w_rd_done    = (r_state == DATA) && rvalid;
  // A flush arriving in the same cycle as the response also discards it
  assign w_discard    = r_drop || flush;

  // Next-state decode and the combinational stall request
  always_comb begin
    w_next   = r_state;
    stallreq = ce && !r_drop && !w_rd_done && !w_misal_fire;
    case (r_state)
      IDLE:    if (w_start && !w_misal) w_next = ADDR;
      ADDR:    if (arready)             w_next = DATA;
      DATA:    if (rvalid)              w_next = IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  // State register; arvalid/rready registered straight from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      r_state <= w_next;
      arvalid <= (w_next == ADDR);
      rready  <= (w_next == DATA);
    end
  end

  // Address latch, instruction capture and drop tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr     <= 32'h0;
      inst       <= 32'h0;
      inst_valid <= 1'b0;
      inst_err   <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      if ((r_state == IDLE) && w_start && !w_misal)
        araddr <= pc;
      if (w_misal_fire) begin
        inst       <= 32'h0;
        inst_err   <= 1'b1;
        inst_valid <= 1'b1;
      end
      if (w_rd_done && !w_discard) begin
        inst       <= rdata;
        inst_err   <= (rresp != 2'b00);
        inst_valid <= 1'b1;
      end
      if (w_rd_done)
        r_drop <= 1'b0;
      else if (flush && (r_state != IDLE))
        r_drop <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_axi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_axi
//  Function : Directed self-checking bench for inst_fetch_axi. Inputs change
//             on the falling edge; outputs are checked 1ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_axi;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic        flush;
  logic        id_stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_err;
  logic        stallreq;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks;
  int n_fails;

  inst_fetch_axi dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ce         (ce),
    .flush      (flush),
    .id_stall   (id_stall),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_err   (inst_err),
    .stallreq   (stallreq),
    .araddr     (araddr),
    .arprot     (arprot),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; pc = 32'h0; ce = 1'b0; flush = 1'b0; id_stall = 1'b0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_inst",    inst,       32'h0);
    chk("rst_valid",   inst_valid, 32'h0);
    chk("rst_err",     inst_err,   32'h0);
    chk("rst_arvalid", arvalid,    32'h0);
    chk("rst_rready",  rready,     32'h0);
    chk("rst_araddr",  araddr,     32'h0);
    chk("arprot",      arprot,     32'h4);

    // Zero-wait fetch at pc=0
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; pc = 32'h0; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'h24080001; rresp = 2'b00;
    #1;
    chk("t1_c0_stallreq", stallreq, 32'h1);
    chk("t1_c0_arvalid",  arvalid,  32'h0);
    @(negedge clk); #1;
    chk("t1_c1_arvalid",  arvalid,  32'h1);
    chk("t1_c1_araddr",   araddr,   32'h0);
    chk("t1_c1_rready",   rready,   32'h0);
    chk("t1_c1_stallreq", stallreq, 32'h1);
    @(negedge clk); #1;
    chk("t1_c2_rready",   rready,   32'h1);
    chk("t1_c2_arvalid",  arvalid,  32'h0);
    chk("t1_c2_stallreq", stallreq, 32'h0);
    // Cycle 3: word delivered, next fetch at pc=4 with a slow arready
    @(negedge clk);
    pc = 32'h4; arready = 1'b0; rvalid = 1'b0;
    #1;
    chk("t1_c3_valid",    inst_valid, 32'h1);
    chk("t1_c3_inst",     inst,       32'h24080001);
    chk("t1_c3_err",      inst_err,   32'h0);
    chk("t1_c3_stallreq", stallreq,   32'h1);

    // arready delayed 3 cycles at pc=4
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      arready = (i == 3);
      #1;
      chk("t2_arvalid",  arvalid,    32'h1);
      chk("t2_araddr",   araddr,     32'h4);
      chk("t2_stallreq", stallreq,   32'h1);
      chk("t2_novalid",  inst_valid, 32'h0);
    end
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h8C090004;
    #1;
    chk("t2_rready",   rready,   32'h1);
    chk("t2_stallreq", stallreq, 32'h0);
    @(negedge clk);
    ce = 1'b0; rvalid = 1'b0;
    #1;
    chk("t2_valid", inst_valid, 32'h1);
    chk("t2_inst",  inst,       32'h8C090004);
    @(negedge clk); #1;
    chk("t2_single_pulse", inst_valid, 32'h0);
    chk("t2_idle_stall",   stallreq,   32'h0);

    // SLVERR response
    @(negedge clk);
    ce = 1'b1; pc = 32'h8; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'hDEADBEEF; rresp = 2'b10;
    @(negedge clk); #1;
    chk("t3_araddr", araddr, 32'h8);
    @(negedge clk); #1;
    chk("t3_rready", rready, 32'h1);
    @(negedge clk);
    ce = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    #1;
    chk("t3_valid", inst_valid, 32'h1);
    chk("t3_inst",  inst,       32'hDEADBEEF);
    chk("t3_err",   inst_err,   32'h1);

    // Flush during DATA, response two cycles later
    @(negedge clk);
    ce = 1'b1; pc = 32'hC; arready = 1'b1; rvalid = 1'b0;
    @(negedge clk); #1;
    chk("t4_arvalid", arvalid, 32'h1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("t4_rready", rready, 32'h1);
    @(negedge clk);
    flush = 1'b0; pc = 32'h100;
    #1;
    chk("t4_drop_stall",  stallreq, 32'h0);
    chk("t4_drop_rready", rready,   32'h1);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h55555555;
    #1;
    chk("t4_drop_stall2", stallreq, 32'h0);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("t4_no_valid",  inst_valid, 32'h0);
    chk("t4_inst_hold", inst,       32'hDEADBEEF);
    chk("t4_new_stall", stallreq,   32'h1);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h12345678;
    #1;
    chk("t4_new_arvalid", arvalid, 32'h1);
    chk("t4_new_araddr",  araddr,  32'h100);
    @(negedge clk); #1;
    chk("t4_new_rready", rready, 32'h1);
    @(negedge clk);
    ce = 1'b0; rvalid = 1'b0;
    #1;
    chk("t4_new_valid", inst_valid, 32'h1);
    chk("t4_new_inst",  inst,       32'h12345678);
    chk("t4_new_err",   inst_err,   32'h0);

    // Misaligned pc
    @(negedge clk);
    ce = 1'b1; pc = 32'h6;
    #1;
    chk("t5_stallreq", stallreq, 32'h0);
    @(negedge clk);
    ce = 1'b0;
    #1;
    chk("t5_arvalid", arvalid,    32'h0);
    chk("t5_valid",   inst_valid, 32'h1);
    chk("t5_err",     inst_err,   32'h1);
    chk("t5_inst",    inst,       32'h0);

    // id_stall holds off the fetch for 4 cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ce = 1'b1; pc = 32'h20; id_stall = 1'b1; arready = 1'b0;
      #1;
      chk("t6_arvalid",  arvalid,  32'h0);
      chk("t6_stallreq", stallreq, 32'h1);
    end
    @(negedge clk);
    id_stall = 1'b0;
    #1;
    chk("t6_release_arvalid", arvalid, 32'h0);
    @(negedge clk); #1;
    chk("t6_start_arvalid", arvalid, 32'h1);
    chk("t6_start_araddr",  araddr,  32'h20);

    // Asynchronous reset while in ADDR
    #2 rst = 1'b1;
    #1;
    chk("t7_arvalid", arvalid,    32'h0);
    chk("t7_araddr",  araddr,     32'h0);
    chk("t7_inst",    inst,       32'h0);
    chk("t7_err",     inst_err,   32'h0);
    @(negedge clk);
    rst = 1'b0; ce = 1'b0;
    @(negedge clk); #1;
    chk("t7_post_arvalid", arvalid, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
